// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared types for the ULA and its round-robin arbiter wrapper.
//   alu_op_t    : 2-bit ALUControl encoding understood by the ULA
//   arb_state_t : sequencing states of ula_arbiter
// ----------------------------------------------------------------------------
package ula_pkg;

    typedef enum logic [1:0] {
        ULA_ADD = 2'b00,
        ULA_SUB = 2'b01,
        ULA_AND = 2'b10,
        ULA_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ula.sv
// ----------------------------------------------------------------------------
// ula
// Combinational 32-bit (WIDTH-bit) arithmetic/logic unit.
// Ports:
//   a, b        in  WIDTH  operands
//   alu_control in  2      00 ADD, 01 SUB (a-b), 10 AND, 11 OR
//   y           out WIDTH  result, modulo 2^WIDTH, no carry/overflow
// ----------------------------------------------------------------------------
module ula
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_control,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op_t'(alu_control))
            ULA_ADD: y = a + b;
            ULA_SUB: y = a - b;
            ULA_AND: y = a & b;
            ULA_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/ula_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ula_rr_arbiter
// Combinational round-robin pick: first valid requester at or above ptr,
// wrapping to the lowest indices below ptr.
// Ports:
//   valid     in  NREQ  request vector
//   ptr       in  IDW   highest-priority index
//   grant     out NREQ  one-hot grant (all zero when nothing is valid)
//   grant_idx out IDW   encoded grant index (0 when nothing is valid)
//   any       out 1     at least one requester is valid
// ----------------------------------------------------------------------------
module ula_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    // Two passes over fixed indices: the upper segment [ptr..NREQ-1] first,
    // then the wrapped segment [0..ptr-1].
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && (i >= int'(ptr)) && valid[i]) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && (i < int'(ptr)) && valid[i]) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// ----------------------------------------------------------------------------
// ula_arbiter
// Shares one ULA between NREQ requesters. IDLE arbitrates round-robin and
// captures the winner's operands, EXEC drives the ULA from the captured
// operands, RESP holds the registered result until the consumer takes it.
// Optional feature macro: ULA_ARB_FLAGS_EN adds registered rsp_zero/rsp_neg.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   req_valid/ready  NREQ-bit request handshake
//   req_a, req_b     NREQ x WIDTH operands
//   req_op           NREQ x 2 ALUControl
//   rsp_valid/ready  response handshake
//   rsp_y            WIDTH result
//   rsp_id           IDW index of the issuing requester
//   rsp_zero/rsp_neg result flags (ULA_ARB_FLAGS_EN only)
// ----------------------------------------------------------------------------
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    input  logic [NREQ-1:0][1:0]       req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_y,
    output logic [IDW-1:0]             rsp_id
`ifdef ULA_ARB_FLAGS_EN
    ,
    output logic                       rsp_zero,
    output logic                       rsp_neg
`endif
);

    arb_state_t       state, state_next;
    logic [IDW-1:0]   ptr;
    logic [WIDTH-1:0] a_q, b_q;
    alu_op_t          op_q;
    logic [IDW-1:0]   id_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] ula_y;
    logic             accept;

    ula_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // The ULA only ever sees the captured operands, so requesters may change
    // or drop their inputs freely once accepted.
    ula #(
        .WIDTH (WIDTH)
    ) u_ula (
        .a           (a_q),
        .b           (b_q),
        .alu_control (op_q),
        .y           (ula_y)
    );

    assign accept = (state == IDLE) && grant_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_any) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= ULA_ADD;
            id_q <= '0;
        end else if (accept) begin
            a_q  <= req_a[grant_idx];
            b_q  <= req_b[grant_idx];
            op_q <= alu_op_t'(req_op[grant_idx]);
            id_q <= grant_idx;
            ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Response register: loaded at the end of EXEC, held through RESP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
`ifdef ULA_ARB_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
`endif
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_y     <= ula_y;
            rsp_id    <= id_q;
`ifdef ULA_ARB_FLAGS_EN
            rsp_zero  <= (ula_y == '0);
            rsp_neg   <= ula_y[WIDTH-1];
`endif
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
